dmi_arbiter: RTL

- Core-clock arbiter that shares the debug module (DM) register bus between two requesters.
- Requester 0 is the DTM DMI path, after CDC synchronisation. Requester 1 is the memory-mapped system debug port.
- Allows one outstanding transaction, with round-robin grant, a req/ack handshake toward the DM, and a timeout that converts a hung DM access into an error response.

---
 rtl/dmi_arbiter_if.sv | 53 +++++
 rtl/dmi_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter_if.sv
// Requester and DM register-bus signals shared by the arbiter and its environment.
// The slave modport is the arbiter side; the master modport is the requester/DM side.
interface dmi_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              r0_req_i;
    logic              r0_we_i;
    logic [ADDR_W-1:0] r0_addr_i;
    logic [DATA_W-1:0] r0_wdata_i;
    logic              r0_gnt_o;
    logic              r0_rvalid_o;
    logic [DATA_W-1:0] r0_rdata_o;
    logic              r0_err_o;

    logic              r1_req_i;
    logic              r1_we_i;
    logic [ADDR_W-1:0] r1_addr_i;
    logic [DATA_W-1:0] r1_wdata_i;
    logic              r1_gnt_o;
    logic              r1_rvalid_o;
    logic [DATA_W-1:0] r1_rdata_o;
    logic              r1_err_o;

    logic              dm_req_o;
    logic              dm_we_o;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [DATA_W-1:0] dm_wdata_o;
    logic              dm_ack_i;
    logic [DATA_W-1:0] dm_rdata_i;
    logic              dm_err_i;
    logic              busy_o;

    modport slave (
        input  r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
        output r0_gnt_o, r0_rvalid_o, r0_rdata_o, r0_err_o,
        input  r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
        output r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o,
        output dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
        input  dm_ack_i, dm_rdata_i, dm_err_i,
        output busy_o
    );

    modport master (
        output r0_req_i, r0_we_i, r0_addr_i, r0_wdata_i,
        input  r0_gnt_o, r0_rvalid_o, r0_rdata_o, r0_err_o,
        output r1_req_i, r1_we_i, r1_addr_i, r1_wdata_i,
        input  r1_gnt_o, r1_rvalid_o, r1_rdata_o, r1_err_o,
        input  dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o,
        output dm_ack_i, dm_rdata_i, dm_err_i,
        input  busy_o
    );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the DM register bus between DMI and system debug port, one access in flight.
// Latency gnt->rvalid = 2 + ack delay; requests are only looked at in IDLE, hung DM accesses time out to an error.
module dmi_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    dmi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic              owner_q, owner_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
    logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
    logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
    logic              r0_err_q, r0_err_d;
    logic              r1_err_q, r1_err_d;

    logic              winner;
    logic              gnt0, gnt1;
    logic              resp_vld;
    logic [DATA_W-1:0] resp_dat;
    logic              resp_err;

    // Under contention the requester that did not go last wins, so grants alternate.
    always_comb begin
        if (bus.r0_req_i && bus.r1_req_i) begin
            winner = ~last_owner_q;
        end else begin
            winner = bus.r1_req_i && !bus.r0_req_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        dm_we_d      = dm_we_q;
        dm_addr_d    = dm_addr_q;
        dm_wdata_d   = dm_wdata_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        r0_err_d     = r0_err_q;
        r1_err_d     = r1_err_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        resp_vld     = 1'b0;
        resp_dat     = '0;
        resp_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.r0_req_i || bus.r1_req_i) begin
                    gnt0         = !winner;
                    gnt1         = winner;
                    owner_d      = winner;
                    last_owner_d = winner;
                    cnt_d        = '0;
                    dm_we_d      = winner ? bus.r1_we_i    : bus.r0_we_i;
                    dm_addr_d    = winner ? bus.r1_addr_i  : bus.r0_addr_i;
                    dm_wdata_d   = winner ? bus.r1_wdata_i : bus.r0_wdata_i;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (bus.dm_ack_i) begin
                    resp_vld = 1'b1;
                    resp_dat = dm_we_q ? '0 : bus.dm_rdata_i;
                    resp_err = bus.dm_err_i;
                end else if (cnt_q == CNT_LAST) begin
                    resp_vld = 1'b1;
                    resp_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (resp_vld) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Load the owner's response registers on entry to RESP so they are visible with rvalid.
        if (resp_vld) begin
            if (owner_q) begin
                r1_rdata_d = resp_dat;
                r1_err_d   = resp_err;
            end else begin
                r0_rdata_d = resp_dat;
                r0_err_d   = resp_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            dm_we_q      <= dm_we_d;
            dm_addr_q    <= dm_addr_d;
            dm_wdata_q   <= dm_wdata_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
            r0_err_q     <= r0_err_d;
            r1_err_q     <= r1_err_d;
        end
    end

    assign bus.r0_gnt_o    = gnt0;
    assign bus.r1_gnt_o    = gnt1;
    assign bus.r0_rvalid_o = (state_q == RESP) && !owner_q;
    assign bus.r1_rvalid_o = (state_q == RESP) && owner_q;
    assign bus.r0_rdata_o  = r0_rdata_q;
    assign bus.r1_rdata_o  = r1_rdata_q;
    assign bus.r0_err_o    = r0_err_q;
    assign bus.r1_err_o    = r1_err_q;
    assign bus.dm_req_o    = (state_q == ISSUE);
    assign bus.dm_we_o     = dm_we_q;
    assign bus.dm_addr_o   = dm_addr_q;
    assign bus.dm_wdata_o  = dm_wdata_q;
    assign bus.busy_o      = (state_q != IDLE);
endmodule
